// File: rtl/gbsha_decim_pkg.sv
// Control-state type for the decimator front end.
// Only the state encoding lives here; sizing is derived locally from parameters.
package gbsha_decim_pkg;

  typedef enum logic {
    WARMUP = 1'b0,
    ACCUM  = 1'b1
  } state_e;

endpackage

// File: rtl/gbsha_decim_if.sv
// Sample-in / decimated-out bundle for gbsha_decim.
// The producer side drives samples and out_ready; the decimator drives results.
interface gbsha_decim_if #(
  parameter int BW_IN  = 8,
  parameter int BW_OUT = 8
);
  logic signed [BW_IN-1:0]  y_in;
  logic                     y_valid;
  logic signed [BW_OUT-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     overrun;

  modport master (
    output y_in, y_valid, out_ready,
    input  out_data, out_valid, overrun
  );

  modport slave (
    input  y_in, y_valid, out_ready,
    output out_data, out_valid, overrun
  );
endinterface

// File: rtl/gbsha_fifo2.sv
// Two-entry shifting FIFO with valid/ready on both sides.
// Entry e0 is always the head; a full FIFO still accepts when it pops.
module gbsha_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         pop, push;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = e0_q;
  assign pop       = out_valid && out_ready;
  assign in_ready  = (cnt_q != 2'd2) || pop;
  assign push      = in_valid && in_ready;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    unique case (cnt_q)
      2'd0: begin
        if (push) begin
          e0_d  = in_data;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          e0_d = in_data;
        end else if (push) begin
          e1_d  = in_data;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      default: begin
        if (pop) begin
          e0_d = e1_q;
          if (push) e1_d = in_data;
          else      cnt_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/gbsha_decim.sv
// Block-average decimator: warm-up, DECIM-sample accumulate, floor-shift,
// saturate, then queue results in a 2-entry FIFO with a sticky overrun.
module gbsha_decim
  import gbsha_decim_pkg::*;
#(
  parameter int N_TAPS = 5,
  parameter int BW_IN  = 8,
  parameter int DECIM  = 4,
  parameter int BW_OUT = 8
) (
  input  logic         clk,
  input  logic         reset,
  gbsha_decim_if.slave bus
);
  localparam int LOG2D = $clog2(DECIM);
  localparam int AW    = BW_IN + LOG2D;
  localparam int WW    = $clog2(N_TAPS + 1);
  localparam int OMAX  = (1 << (BW_OUT - 1)) - 1;
  localparam int OMIN  = -(1 << (BW_OUT - 1));

  state_e                   state_q;
  logic [WW-1:0]            warm_q;
  logic signed [AW-1:0]     acc_q;
  logic [LOG2D-1:0]         ph_q;
  logic                     ovr_q;

  logic                     take, last;
  logic                     push_v, push_rdy;
  logic signed [AW-1:0]     sum, shr;
  logic signed [BW_OUT-1:0] res;
  logic [BW_OUT-1:0]        fifo_data;

  assign take   = (state_q == ACCUM) && bus.y_valid;
  assign last   = (ph_q == LOG2D'(DECIM - 1));
  assign push_v = take && last;
  assign sum    = acc_q + AW'(bus.y_in);
  assign shr    = sum >>> LOG2D;

  // Shift is a floor divide; clamp only matters when BW_OUT < BW_IN.
  always_comb begin
    res = BW_OUT'(shr);
    if (int'(shr) > OMAX)      res = BW_OUT'(OMAX);
    else if (int'(shr) < OMIN) res = BW_OUT'(OMIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WARMUP;
      warm_q  <= '0;
      acc_q   <= '0;
      ph_q    <= '0;
      ovr_q   <= 1'b0;
    end else begin
      unique case (state_q)
        WARMUP: begin
          if (warm_q == WW'(N_TAPS - 1)) state_q <= ACCUM;
          else                           warm_q  <= warm_q + WW'(1);
        end
        ACCUM: begin
          if (take) begin
            if (last) begin
              acc_q <= '0;
              ph_q  <= '0;
            end else begin
              acc_q <= sum;
              ph_q  <= ph_q + LOG2D'(1);
            end
          end
        end
        default: state_q <= WARMUP;
      endcase
      if (push_v && !push_rdy) ovr_q <= 1'b1;
    end
  end

  gbsha_fifo2 #(.W(BW_OUT)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (push_v),
    .in_ready  (push_rdy),
    .in_data   (res),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (fifo_data)
  );

  assign bus.out_data = fifo_data;
  assign bus.overrun  = ovr_q;
endmodule
